vote_capture: RTL and testbench

- Front-end stage that sits directly upstream of the vote logger and drives its four candN_vote_valid inputs.
- Conditions raw candidate push-buttons: synchronise, then debounce.
- Enforces one vote per press: at most one single-cycle, one-hot vote pulse per voter session, then a lockout interval before the next voter.
- Rejects simultaneous presses. Inactive while mode=1 (result/display mode).

---
 rtl/vote_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 43 ++++
 rtl/vote_capture.sv | 109 ++++++++++
 tb/tb_vote_capture.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared definitions for the vote capture front-end: candidate count, capture
// FSM encoding, default timing constants and a one-hot helper.
package vote_pkg;

  localparam int NUM_CAND = 4;

  localparam logic [15:0] DEFAULT_DEBOUNCE_CYCLES = 16'd50000;
  localparam logic [23:0] DEFAULT_LOCKOUT_CYCLES  = 24'd1000000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    VOTE    = 3'd2,
    REJECT  = 3'd3,
    HOLD    = 3'd4,
    LOCKOUT = 3'd5
  } capture_state_e;

  function automatic logic is_onehot(input logic [NUM_CAND-1:0] v);
    return (v != '0) && ((v & (v - NUM_CAND'(1))) == '0);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter; the debounced level
// only changes after DEBOUNCE_CYCLES consecutive disagreeing samples.
module btn_debounce
  import vote_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 16'd1);

  logic          meta;
  logic          synced;
  logic [CW-1:0] cnt;

  // NOTE: every register here uses non-blocking assignment so meta->synced
  // forms two real flops instead of collapsing into one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta   <= 1'b0;
      synced <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
    end else begin
      meta   <= raw;
      synced <= meta;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/vote_capture.sv
// Button front-end for the vote logger: debounces four candidate buttons and
// emits at most one one-hot vote (or a conflict) per voter session.
module vote_capture
  import vote_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [23:0] LOCKOUT_CYCLES  = DEFAULT_LOCKOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic mode,
  input  logic cand1_btn,
  input  logic cand2_btn,
  input  logic cand3_btn,
  input  logic cand4_btn,
  output logic cand1_vote_valid,
  output logic cand2_vote_valid,
  output logic cand3_vote_valid,
  output logic cand4_vote_valid,
  output logic conflict,
  output logic busy
);

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 24'd1);

  logic [NUM_CAND-1:0] raw;
  logic [NUM_CAND-1:0] db;
  logic [NUM_CAND-1:0] vote;
  capture_state_e      state;
  logic [LW-1:0]       lock_cnt;

  assign raw = {cand4_btn, cand3_btn, cand2_btn, cand1_btn};

  for (genvar i = 0; i < NUM_CAND; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .level(db[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      vote     <= '0;
      conflict <= 1'b0;
      lock_cnt <= '0;
    end else if (mode) begin
      state    <= IDLE;
      vote     <= '0;
      conflict <= 1'b0;
      lock_cnt <= '0;
    end else begin
      // NOTE: pulse outputs default low each cycle; only the deciding ARMED
      // cycle overrides them, which keeps every pulse exactly one cycle wide.
      vote     <= '0;
      conflict <= 1'b0;
      case (state)
        IDLE: begin
          if (db == '0) state <= ARMED;
        end
        ARMED: begin
          if (is_onehot(db)) begin
            state <= VOTE;
            vote  <= db;
          end else if (db != '0) begin
            state    <= REJECT;
            conflict <= 1'b1;
          end
        end
        VOTE, REJECT: begin
          state <= HOLD;
        end
        HOLD: begin
          if (db == '0) begin
            state    <= LOCKOUT;
            lock_cnt <= '0;
          end
        end
        LOCKOUT: begin
          // A press during lockout restarts the whole release-and-wait cycle.
          if (db != '0) begin
            state    <= HOLD;
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_LAST) begin
            state    <= ARMED;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign cand1_vote_valid = vote[0];
  assign cand2_vote_valid = vote[1];
  assign cand3_vote_valid = vote[2];
  assign cand4_vote_valid = vote[3];
  assign busy             = (state != ARMED);

endmodule

// File: tb/tb_vote_capture.sv
// Self-checking bench for vote_capture: a cycle reference model checks every
// output each cycle, plus a vector table, scenario sequences and random stimulus.
module tb_vote_capture;

  localparam int D = 4;
  localparam int L = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       c1, c2, c3, c4, conflict, busy;

  vote_capture #(
    .DEBOUNCE_CYCLES(16'(D)),
    .LOCKOUT_CYCLES (24'(L))
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mode            (mode),
    .cand1_btn       (btn[0]),
    .cand2_btn       (btn[1]),
    .cand3_btn       (btn[2]),
    .cand4_btn       (btn[3]),
    .cand1_vote_valid(c1),
    .cand2_vote_valid(c2),
    .cand3_vote_valid(c3),
    .cand4_vote_valid(c4),
    .conflict        (conflict),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Observed-pulse bookkeeping for scenario checks.
  int         n_votes, n_conf, n_busy_low, first_vote_cyc;
  logic [3:0] seen_vote;

  // Reference model: delayed raw samples, a window of the last D synced samples
  // per button, and a session view of the voter (armed / cooldown / quiet run).
  logic [3:0]   m_s1 = '0, m_s2 = '0, m_db = '0;
  logic [D-1:0] m_win [4];
  bit           m_valid = 0, m_armed = 0, m_cool = 0;
  int           m_run = 0, m_need = 1;
  logic [3:0]   exp_vote;
  logic         exp_conf, exp_busy;

  typedef struct {
    logic [3:0] btns;
    int         hold;
    logic [3:0] exp_vote;
    logic       exp_conf;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [3:0] old_db;
    old_db   = m_db;
    exp_vote = '0;
    exp_conf = 1'b0;
    if (!reset || mode) begin
      // Session starts over; only a single quiet sample is needed to arm.
      m_armed = 0; m_cool = 0; m_run = 0; m_need = 1;
    end else if (m_armed) begin
      if (old_db != '0) begin
        if ($countones(old_db) == 1) exp_vote = old_db;
        else exp_conf = 1'b1;
        m_armed = 0; m_cool = 1; m_run = 0;
        m_need = L + 1;  // one sample to leave HOLD plus L lockout samples
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else begin
      if (old_db == '0) m_run++;
      else m_run = 0;
      if (m_run >= m_need) begin
        m_armed = 1;
        m_run   = 0;
      end
    end
    exp_busy = !m_armed;
    if (!reset) begin
      m_valid = 1;
      m_s1 = '0; m_s2 = '0; m_db = '0;
      for (int b = 0; b < 4; b++) m_win[b] = '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        m_win[b] = {m_win[b][D-2:0], m_s2[b]};
        if (m_win[b] == {D{~m_db[b]}}) m_db[b] = ~m_db[b];
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      cyc++;
      #1;
      if (m_valid) begin
        check("vote", {c4, c3, c2, c1}, exp_vote);
        check("conflict", conflict, exp_conf);
        check("busy", busy, exp_busy);
      end
      if ({c4, c3, c2, c1} != 4'b0000) begin
        n_votes++;
        seen_vote |= {c4, c3, c2, c1};
        if (first_vote_cyc < 0) first_vote_cyc = cyc;
      end
      if (conflict === 1'b1) n_conf++;
      if (busy === 1'b0) n_busy_low++;
    end
  endtask

  task automatic clear_counts();
    n_votes = 0; n_conf = 0; n_busy_low = 0; first_vote_cyc = -1; seen_vote = '0;
  endtask

  task automatic press(input logic [3:0] b, input int hold);
    btn = b;
    step(hold);
    btn = 4'b0000;
  endtask

  task automatic wait_armed(input string name);
    for (int i = 0; i < 200 && busy !== 1'b0; i++) step(1);
    check(name, busy, 1'b0);
  endtask

  initial begin
    int press_cyc, hold_left, r;

    vecs[0]  = '{4'b0001, 10,    4'b0001, 1'b0};
    vecs[1]  = '{4'b0010, 10,    4'b0010, 1'b0};
    vecs[2]  = '{4'b0100, 10,    4'b0100, 1'b0};
    vecs[3]  = '{4'b1000, 10,    4'b1000, 1'b0};
    vecs[4]  = '{4'b0011, 10,    4'b0000, 1'b1};
    vecs[5]  = '{4'b1100, 10,    4'b0000, 1'b1};
    vecs[6]  = '{4'b0111, 10,    4'b0000, 1'b1};
    vecs[7]  = '{4'b1111, 10,    4'b0000, 1'b1};
    vecs[8]  = '{4'b0100, D - 1, 4'b0000, 1'b0};  // one sample short of debounce
    vecs[9]  = '{4'b0100, D,     4'b0100, 1'b0};  // exactly long enough
    vecs[10] = '{4'b1001, 10,    4'b0000, 1'b1};

    clear_counts();

    // Reset, then a clean cand2 press.
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(5);
    check("t1_armed_after_reset", n_busy_low > 0, 1'b1);
    clear_counts();
    btn = 4'b0010;
    press_cyc = cyc + 1;
    step(20);
    btn = 4'b0000;
    step(5);
    check("t1_pulses", n_votes, 1);
    check("t1_which", seen_vote, 4'b0010);
    check("t1_latency", first_vote_cyc - press_cyc, D + 2);
    check("t1_no_conflict", n_conf, 0);
    check("t1_busy_after", busy, 1'b1);

    // Table of single presses from the armed state.
    foreach (vecs[i]) begin
      wait_armed($sformatf("vec%0d_armed", i));
      clear_counts();
      press(vecs[i].btns, vecs[i].hold);
      step(40);
      check($sformatf("vec%0d_votes", i), seen_vote, vecs[i].exp_vote);
      check($sformatf("vec%0d_npulse", i), n_votes, (vecs[i].exp_vote != 0) ? 1 : 0);
      check($sformatf("vec%0d_conf", i), n_conf, vecs[i].exp_conf ? 1 : 0);
    end

    // Bouncing cand1, then held for 100 cycles.
    wait_armed("t2_armed");
    clear_counts();
    for (int i = 0; i < 6; i++) begin
      btn = 4'b0001; step(2);
      btn = 4'b0000; step(2);
    end
    check("t2_bounce_quiet", n_votes, 0);
    press(4'b0001, 100);
    step(5);
    check("t2_one_pulse", n_votes, 1);
    check("t2_which", seen_vote, 4'b0001);

    // Simultaneous cand3+cand4, then cand4 alone.
    wait_armed("t3_armed");
    clear_counts();
    press(4'b1100, 10);
    step(30);
    check("t3_conflict", n_conf, 1);
    check("t3_no_vote", n_votes, 0);
    clear_counts();
    press(4'b1000, 10);
    step(30);
    check("t3_cand4", seen_vote, 4'b1000);
    check("t3_cand4_n", n_votes, 1);

    // Re-press three cycles into lockout restarts it without a vote.
    wait_armed("t4_armed");
    press(4'b0001, 10);
    step(4);
    clear_counts();
    press(4'b0001, 10);
    step(5);
    check("t4_no_pulse", n_votes, 0);
    check("t4_busy_held", n_busy_low, 0);
    step(25);
    clear_counts();
    press(4'b0001, 10);
    step(30);
    check("t4_repress_vote", n_votes, 1);

    // Reset during lockout with cand2 held: reset clears the debounced level,
    // so IDLE sees db==0 at once and the still-held press debounces into a vote.
    wait_armed("t5_armed");
    press(4'b0010, 10);
    step(8);
    check("t5_in_lockout", busy, 1'b1);
    clear_counts();
    btn   = 4'b0010;
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(20);
    check("t5_held_vote", n_votes, 1);
    btn = 4'b0000;
    step(30);
    clear_counts();
    press(4'b0010, 10);
    step(30);
    check("t5_second_vote", n_votes, 1);

    // Result mode: no capture; held button on return blocks until released.
    clear_counts();
    mode = 1'b1;
    btn  = 4'b0010;
    step(20);
    check("t6_mode_no_vote", n_votes, 0);
    check("t6_mode_busy", n_busy_low, 0);
    mode = 1'b0;
    step(20);
    check("t6_stuck_blocked", n_votes + n_busy_low, 0);
    btn = 4'b0000;
    step(10);
    check("t6_armed", busy, 1'b0);
    clear_counts();
    press(4'b0010, 10);
    step(30);
    check("t6_vote", n_votes, 1);

    // Random stimulus against the reference model.
    hold_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold_left <= 0) begin
        r = $urandom_range(0, 15);
        if (r < 6)       btn = 4'b0000;
        else if (r < 12) btn = 4'(1 << $urandom_range(0, 3));
        else             btn = 4'($urandom);
        hold_left = $urandom_range(1, 14);
      end
      if ($urandom_range(0, 299) == 0) mode = ~mode;
      reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      step(1);
      hold_left--;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
